// File: rtl/ff_bank_exerciser_if.sv
// rtl/ff_bank_exerciser_if.sv - signal bundle between the exerciser and the four-flip-flop bank
interface ff_bank_exerciser_if;
  logic s, r, d, j, k, t, tclr;
  logic qsr, qsrbar, qd, qdbar, qjk, qjkbar, qt, qtbar;

  modport master (
    output s, r, d, j, k, t, tclr,
    input  qsr, qsrbar, qd, qdbar, qjk, qjkbar, qt, qtbar
  );

  modport slave (
    input  s, r, d, j, k, t, tclr,
    output qsr, qsrbar, qd, qdbar, qjk, qjkbar, qt, qtbar
  );
endinterface

// File: rtl/ff_bank_exerciser.sv
// rtl/ff_bank_exerciser.sv - clears the flip-flop bank, drives LFSR vectors and checks it against a reference model
module ff_bank_exerciser #(
  parameter int unsigned NVEC = 16,
  parameter logic [7:0]  SEED = 8'hA5
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       start,
  ff_bank_exerciser_if.master        bank,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [7:0]                 err_count,
  output logic [7:0]                 fail_vec,
  output logic [3:0]                 fail_mask
);
  localparam logic [7:0] EFF_SEED = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [7:0] LAST_IDX = 8'(NVEC - 1);

  typedef enum logic [2:0] {IDLE, INIT, INIT_CHK, APPLY, SETTLE, DONE} state_t;
  state_t state;

  logic [7:0] lfsr, lfsr_next, vec_idx, err_next;
  logic       m_sr, m_d, m_jk, m_t;
  logic [3:0] mask;
  logic       chk;

  always_comb begin
    lfsr_next = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
    mask[0]   = (bank.qsr != m_sr) | (bank.qsrbar != !m_sr);
    mask[1]   = (bank.qd  != m_d)  | (bank.qdbar  != !m_d);
    mask[2]   = (bank.qjk != m_jk) | (bank.qjkbar != !m_jk);
    mask[3]   = (bank.qt  != m_t)  | (bank.qtbar  != !m_t);
    chk       = (state == INIT_CHK) || (state == SETTLE);
    err_next  = (chk && mask != 4'd0 && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      lfsr      <= EFF_SEED;
      vec_idx   <= 8'd0;
      m_sr      <= 1'b0;
      m_d       <= 1'b0;
      m_jk      <= 1'b0;
      m_t       <= 1'b0;
      bank.s    <= 1'b0;
      bank.r    <= 1'b0;
      bank.d    <= 1'b0;
      bank.j    <= 1'b0;
      bank.k    <= 1'b0;
      bank.t    <= 1'b0;
      bank.tclr <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 8'd0;
      fail_vec  <= 8'd0;
      fail_mask <= 4'd0;
    end else begin
      // err_count is still zero until the first mismatch, so it doubles as the first-failure flag
      if (chk && mask != 4'd0 && err_count == 8'd0) begin
        fail_vec  <= (state == INIT_CHK) ? 8'hFF : vec_idx;
        fail_mask <= mask;
      end
      err_count <= err_next;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= INIT;
            busy      <= 1'b1;
            lfsr      <= EFF_SEED;
            vec_idx   <= 8'd0;
            err_count <= 8'd0;
            fail_vec  <= 8'd0;
            fail_mask <= 4'd0;
            pass      <= 1'b0;
            bank.s    <= 1'b0;
            bank.r    <= 1'b1;
            bank.d    <= 1'b0;
            bank.j    <= 1'b0;
            bank.k    <= 1'b1;
            bank.t    <= 1'b0;
            bank.tclr <= 1'b1;
          end
        end
        INIT: begin
          state     <= INIT_CHK;
          m_sr      <= 1'b0;
          m_d       <= 1'b0;
          m_jk      <= 1'b0;
          m_t       <= 1'b0;
          bank.r    <= 1'b0;
          bank.k    <= 1'b0;
          bank.d    <= 1'b0;
          bank.tclr <= 1'b0;
        end
        INIT_CHK: begin
          state  <= APPLY;
          bank.s <= lfsr[0];
          bank.r <= lfsr[1] & ~lfsr[0];
          bank.d <= lfsr[2];
          bank.j <= lfsr[3];
          bank.k <= lfsr[4];
          bank.t <= lfsr[5];
        end
        APPLY: begin
          state <= SETTLE;
          if (bank.s)      m_sr <= 1'b1;
          else if (bank.r) m_sr <= 1'b0;
          m_d <= bank.d;
          case ({bank.j, bank.k})
            2'b01:   m_jk <= 1'b0;
            2'b10:   m_jk <= 1'b1;
            2'b11:   m_jk <= !m_jk;
            default: m_jk <= m_jk;
          endcase
          if (bank.t) m_t <= !m_t;
          // d keeps the vector value, which is exactly the new D model value
          bank.s <= 1'b0;
          bank.r <= 1'b0;
          bank.j <= 1'b0;
          bank.k <= 1'b0;
          bank.t <= 1'b0;
        end
        SETTLE: begin
          lfsr    <= lfsr_next;
          vec_idx <= vec_idx + 8'd1;
          if (vec_idx < LAST_IDX) begin
            state  <= APPLY;
            bank.s <= lfsr_next[0];
            bank.r <= lfsr_next[1] & ~lfsr_next[0];
            bank.d <= lfsr_next[2];
            bank.j <= lfsr_next[3];
            bank.k <= lfsr_next[4];
            bank.t <= lfsr_next[5];
          end else begin
            state  <= DONE;
            done   <= 1'b1;
            pass   <= (err_next == 8'd0);
            bank.d <= m_d;
          end
        end
        DONE: begin
          state  <= IDLE;
          done   <= 1'b0;
          busy   <= 1'b0;
          bank.d <= m_d;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ff_bank_exerciser.sv
// tb/tb_ff_bank_exerciser.sv - randomized self-checking bench for ff_bank_exerciser with a behavioural bank
module tb_ff_bank_exerciser;
  logic clk = 1'b0;
  logic clr = 1'b1;
  logic start16 = 1'b0;
  logic start255 = 1'b0;
  always #5 clk = ~clk;

  ff_bank_exerciser_if b16 ();
  ff_bank_exerciser_if b255 ();

  logic       busy16, done16, pass16, busy255, done255, pass255;
  logic [7:0] err16, fv16, err255, fv255;
  logic [3:0] fm16, fm255;

  ff_bank_exerciser #(.NVEC(16), .SEED(8'hA5)) dut16 (
    .clk(clk), .clr(clr), .start(start16), .bank(b16.master),
    .busy(busy16), .done(done16), .pass(pass16),
    .err_count(err16), .fail_vec(fv16), .fail_mask(fm16)
  );

  ff_bank_exerciser #(.NVEC(255), .SEED(8'h00)) dut255 (
    .clk(clk), .clr(clr), .start(start255), .bank(b255.master),
    .busy(busy255), .done(done255), .pass(pass255),
    .err_count(err255), .fail_vec(fv255), .fail_mask(fm255)
  );

  // behavioural bank: 0 = healthy, 1 = qt stuck at 0, 2 = qd stuck at 1
  int   fault = 0;
  logic sr16 = 1'b0, d16 = 1'b0, jk16 = 1'b0, t16 = 1'b0;
  logic sr2 = 1'b0, d2 = 1'b0, jk2 = 1'b0, t2 = 1'b0;

  always @(posedge clk) begin
    if (b16.s) sr16 <= 1'b1; else if (b16.r) sr16 <= 1'b0;
    d16 <= b16.d;
    if (b16.j && b16.k) jk16 <= ~jk16; else if (b16.j) jk16 <= 1'b1; else if (b16.k) jk16 <= 1'b0;
    if (b16.tclr) t16 <= 1'b0; else if (b16.t) t16 <= ~t16;
    if (b255.s) sr2 <= 1'b1; else if (b255.r) sr2 <= 1'b0;
    d2 <= b255.d;
    if (b255.j && b255.k) jk2 <= ~jk2; else if (b255.j) jk2 <= 1'b1; else if (b255.k) jk2 <= 1'b0;
    if (b255.tclr) t2 <= 1'b0; else if (b255.t) t2 <= ~t2;
  end

  assign b16.qsr    = sr16;
  assign b16.qsrbar = ~sr16;
  assign b16.qd     = (fault == 2) ? 1'b1 : d16;
  assign b16.qdbar  = ~d16;
  assign b16.qjk    = jk16;
  assign b16.qjkbar = ~jk16;
  assign b16.qt     = (fault == 1) ? 1'b0 : t16;
  assign b16.qtbar  = ~t16;
  assign b255.qsr    = sr2;
  assign b255.qsrbar = ~sr2;
  assign b255.qd     = d2;
  assign b255.qdbar  = ~d2;
  assign b255.qjk    = jk2;
  assign b255.qjkbar = ~jk2;
  assign b255.qt     = t2;
  assign b255.qtbar  = ~t2;

  int         checks = 0;
  int         failures = 0;
  logic [5:0] vl [256];
  int         e_err;
  logic [7:0] e_fv;
  logic [3:0] e_fm;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // vector list: bits [0]=s [1]=r [2]=d [3]=j [4]=k [5]=t, r suppressed when s and r both set
  task automatic build(input logic [7:0] seed);
    logic [7:0] l;
    l = (seed == 8'h00) ? 8'h01 : seed;
    for (int n = 0; n < 256; n++) begin
      vl[n] = {l[5], l[4], l[3], l[2], l[1] & ~l[0], l[0]};
      l = l[0] ? ((l >> 1) ^ 8'hB8) : (l >> 1);
    end
  endtask

  task automatic note(input logic [7:0] idx, input logic [3:0] m);
    if (m != 4'd0) begin
      if (e_err == 0) begin
        e_fv = idx;
        e_fm = m;
      end
      if (e_err < 255) e_err++;
    end
  endtask

  task automatic expect_run(input int flt, input int nv);
    logic ms, md, mj, mt;
    logic [3:0] m;
    ms = 0; md = 0; mj = 0; mt = 0;
    e_err = 0; e_fv = 8'd0; e_fm = 4'd0;
    for (int n = -1; n < nv; n++) begin
      if (n >= 0) begin
        if (vl[n][0]) ms = 1'b1; else if (vl[n][1]) ms = 1'b0;
        md = vl[n][2];
        if (vl[n][3] && vl[n][4]) mj = ~mj; else if (vl[n][3]) mj = 1'b1; else if (vl[n][4]) mj = 1'b0;
        if (vl[n][5]) mt = ~mt;
      end
      m = 4'd0;
      m[1] = (flt == 2) && (md != 1'b1);
      m[3] = (flt == 1) && (mt != 1'b0);
      note((n < 0) ? 8'hFF : 8'(n), m);
    end
  endtask

  // {busy, done, s, r, d, j, k, t, tclr} expected in cycle c after the start edge
  function automatic logic [8:0] exp_out(input int c, input int nv);
    int n;
    if (c == 1) return 9'b1_0_010010_1;
    if (c == 2) return 9'b1_0_000000_0;
    if (c == 3 + 2 * nv) return 9'b1_1_000000_0;
    if (c == 4 + 2 * nv) return {2'b00, 2'b00, vl[nv-1][2], 4'b0000};
    if (c % 2 == 1) begin
      n = (c - 3) / 2;
      return {2'b10, vl[n][0], vl[n][1], vl[n][2], vl[n][3], vl[n][4], vl[n][5], 1'b0};
    end
    n = (c - 4) / 2;
    return {2'b10, 2'b00, vl[n][2], 4'b0000};
  endfunction

  task automatic run16(input int flt, input int hold, input int rep);
    logic [8:0] e;
    fault = flt;
    build(8'hA5);
    expect_run(flt, 16);
    start16 = 1'b1;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      start16 = (c < hold) || (c == rep);
      e = exp_out(c, 16);
      if (c == 35)
        check($sformatf("ctl16_c%0d", c), {busy16, done16}, e[8:7]);
      else
        check($sformatf("out16_c%0d", c),
              {busy16, done16, b16.s, b16.r, b16.d, b16.j, b16.k, b16.t, b16.tclr}, e);
      if (c >= 35)
        check($sformatf("res16_c%0d", c), {pass16, err16, fv16, fm16},
              {e_err == 0, 8'(e_err), e_fv, e_fm});
    end
  endtask

  task automatic run255();
    logic [8:0] e;
    build(8'h00);
    expect_run(0, 255);
    start255 = 1'b1;
    for (int c = 1; c <= 514; c++) begin
      @(negedge clk);
      start255 = 1'b0;
      e = exp_out(c, 255);
      check("sr255", b255.s & b255.r, 0);
      if (c == 513) begin
        check("ctl255", {busy255, done255}, e[8:7]);
        check("res255", {pass255, err255, fv255, fm255}, {e_err == 0, 8'(e_err), e_fv, e_fm});
      end else
        check($sformatf("out255_c%0d", c),
              {busy255, done255, b255.s, b255.r, b255.d, b255.j, b255.k, b255.t, b255.tclr}, e);
    end
  endtask

  task automatic clr_test();
    int seen;
    fault = 0;
    start16 = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      start16 = 1'b0;
    end
    @(posedge clk);
    #1 clr = 1'b1;
    #2;
    check("clr_out", {busy16, done16, b16.s, b16.r, b16.d, b16.j, b16.k, b16.t, b16.tclr}, 9'b0_0_000000_1);
    check("clr_res", {pass16, err16, fv16, fm16}, 0);
    @(negedge clk);
    clr = 1'b0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done16 || busy16) seen++;
    end
    check("clr_quiet", seen, 0);
  endtask

  initial begin
    @(negedge clk);
    check("rst16", {busy16, done16, b16.s, b16.r, b16.d, b16.j, b16.k, b16.t, b16.tclr}, 9'b0_0_000000_1);
    check("rst16_res", {pass16, err16, fv16, fm16}, 0);
    check("rst255", {busy255, done255, b255.s, b255.r, b255.tclr}, 5'b00001);
    clr = 1'b0;
    @(negedge clk);
    run16(0, 1, 0);
    run16(1, 1, 0);
    run16(2, 1, 0);
    run16(0, 5, 20);
    run16(0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run16(int'($urandom_range(0, 2)), int'($urandom_range(1, 6)),
            ($urandom_range(0, 1) == 1) ? int'($urandom_range(8, 30)) : 0);
    end
    clr_test();
    run16(0, 1, 0);
    run255();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ff_bank_exerciser.md
# ff_bank_exerciser

Self-checking sequencer for the four-flip-flop bank (SR, D, JK, T with clear). On `start` it clears the bank, then applies NVEC pseudo-random stimulus vectors. Each vector is applied for exactly one capture edge. The block compares the bank's outputs against an internal reference model and reports pass/fail, the error count and the first failure. It sits between a board-level start/status interface and the bank, and owns every bank input.

## Interface
- NVEC, 16, number of stimulus vectors per run (1..255)
- SEED, 8'hA5, LFSR seed; a value of 0 is replaced by 8'h01
- clk  in  1  single clock, bank captures on the same rising edge
- clr  in  1  asynchronous, active-high reset
- start  in  1  run request, sampled in IDLE only
- qsr, qsrbar, qd, qdbar, qjk, qjkbar, qt, qtbar  in  1 each  bank outputs
- s, r, d, j, k, t, tclr  out  1 each  bank inputs, registered
- busy  out  1  high from the cycle after `start` is accepted through DONE
- done  out  1  one-cycle pulse in DONE
- pass  out  1  level, updated in DONE: (err_count==0)
- err_count  out  8  vectors with at least one mismatch, saturates at 255
- fail_vec  out  8  index of the first failing check; 8'hFF = init check
- fail_mask  out  4  mismatch bits of the first failure: [0]=SR, [1]=D, [2]=JK, [3]=T

## Operation
- States and transitions:
  - IDLE → INIT on `start`.
  - INIT → INIT_CHK → APPLY.
  - APPLY → SETTLE.
  - SETTLE → APPLY while vec_idx < NVEC-1, else → DONE.
  - DONE → IDLE.
- Bank drive by state (outputs registered, so they change on the edge that enters the state):
  - IDLE, INIT_CHK, SETTLE (hold pattern): s=r=j=k=t=0, tclr=0, d=model_qd.
  - INIT (clear pattern): s=0, r=1, d=0, j=0, k=1, t=0, tclr=1.
  - APPLY: the current vector.
- Vector generation:
  - 8-bit Galois LFSR, polynomial x^8+x^6+x^5+x^4+1, loaded with SEED in INIT.
  - Bit mapping: s=lfsr[0], r=lfsr[1], d=lfsr[2], j=lfsr[3], k=lfsr[4], t=lfsr[5].
  - If lfsr[0]&lfsr[1], r is forced to 0; s=r=1 is never driven.
  - The LFSR advances on the edge leaving SETTLE.
- Reference model:
  - INIT also zeroes err_count, fail_vec, fail_mask, pass and vec_idx.
  - The model registers are set to 0 on the edge leaving INIT.
  - On the edge leaving APPLY the model updates with the vector:
    - SR: s→1, r→0, else hold.
    - D: d.
    - JK: 00 hold, 01 →0, 10 →1, 11 toggle.
    - T: t toggles.
- Check, performed on the edge leaving INIT_CHK and on the edge leaving each SETTLE:
  - A mismatch bit is set if q≠model or qbar≠~model for that flip-flop.
  - Any nonzero mask increments err_count (saturating).
  - The first nonzero mask in a run latches fail_vec (8'hFF for INIT_CHK, else vec_idx) and fail_mask.
- vec_idx increments on the edge leaving SETTLE.
- DONE: done=1 and pass=(err_count==0, including the final check).

## Timing
- Reset values:
  - State IDLE.
  - tclr=1; s, r, d, j, k, t = 0.
  - busy, done, pass = 0; err_count, fail_vec, fail_mask, vec_idx, model = 0.
  - The LFSR is loaded with the effective seed.
- `start` is sampled at edge E0 while in IDLE; it is ignored in every other state, and holding it high restarts only after DONE→IDLE.
- Cycle sequence after E0:
  - INIT occupies cycle 1 and INIT_CHK cycle 2.
  - Vector n is in APPLY during cycle 3+2n and in SETTLE during cycle 4+2n.
  - done is high in cycle 3+2·NVEC, which is cycle 35 for NVEC=16.
- busy is high in cycles 1 .. 3+2·NVEC and low in the cycle after done.
- The hold pattern in SETTLE is mandatory: JK and T must not see a second active edge, and D must recapture the model value.
- `clr` asserted mid-run:
  - All outputs return to their reset values immediately (asynchronously); no done pulse is produced.
  - After `clr` is released the block waits in IDLE for a new `start`.
- err_count, fail_vec, fail_mask and pass are held from DONE until the next INIT.

## Test plan
- Correct bank, NVEC=16, SEED=8'hA5, start pulse at E0 → busy in cycles 1..35, done exactly in cycle 35, pass=1, err_count=0, fail_mask=0.
- Bank with qt stuck at 0, NVEC=16 → pass=0, fail_mask[3]=1, fail_vec = index of the first vector with t=1 (computed by the bench from the LFSR), err_count ≥1.
- Bank powered without clear support (qd stuck at 1) → first failure at INIT_CHK: fail_vec=8'hFF, fail_mask[1]=1.
- Monitor over 255-vector runs with seeds 8'h00, 8'h01 and 8'hA5 → s&r never 1; in every SETTLE, j=k=t=0 and d equals the D model value.
- `clr` pulsed in cycle 10 of a run → all outputs at reset values in the same cycle (tclr=1, busy=0), no done pulse; a new start then gives done at cycle 35 again.
- `start` held high for 5 cycles, then re-pulsed during busy → exactly one run, one done pulse; a start in the cycle after done begins a second run.
